// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetches the program buffer, then runs decoded commands.
// Weight loads stream pages to one engine channel; image processing streams
// image pages to the pre-processor and writes result pages back.
// Optional feature macro: CTRL_SEQ_PERF_EN builds the busy/stall counters.
//
// Handshake rules: a valid (or request) stays high until its ready is seen
// high on a rising edge, and the transfer happens on that edge. Read data
// comes back as a single mem_rd_dvalid pulse, with at most one read in flight.
// A mem_rd_dvalid that arrives while no read is in flight is ignored.
module ctrl_sequencer #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 512,
   parameter int PROG_PAGES = 256,
   parameter int IMG_PAGES  = 1407,
   parameter int RES_PAGES  = 3,
   parameter int NUM_WCH    = 2,
   parameter int CNT_W      = 28,
   parameter int CH_W       = (NUM_WCH > 1) ? $clog2(NUM_WCH) : 1,
   parameter int PROG_IDX_W = (PROG_PAGES > 1) ? $clog2(PROG_PAGES) : 1,
   parameter int IMG_IDX_W  = (IMG_PAGES > 1) ? $clog2(IMG_PAGES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  buffer_addr_valid,
   input  logic [ADDR_W-1:0]     buf_base,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_rd_valid,
   input  logic                  mem_rd_ready,
   input  logic                  mem_rd_dvalid,
   input  logic [DATA_W-1:0]     mem_rd_data,
   output logic                  mem_wr_valid,
   input  logic                  mem_wr_ready,
   output logic [DATA_W-1:0]     mem_wr_data,
   output logic                  prog_page_vld,
   output logic [PROG_IDX_W-1:0] prog_page_idx,
   output logic                  instr_vld,
   output logic                  inc_pc,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [CH_W-1:0]       cmd_ch,
   input  logic [CNT_W-1:0]      cmd_addr,
   input  logic                  reg_wr_en,
   input  logic [1:0]            reg_sel,
   input  logic [CNT_W-1:0]      reg_data,
   input  logic [NUM_WCH-1:0]    wt_req,
   input  logic [NUM_WCH-1:0]    wt_done,
   output logic [NUM_WCH-1:0]    wt_dvalid,
   input  logic                  eng_ready,
   output logic                  img_page_vld,
   output logic [IMG_IDX_W-1:0]  img_page_idx,
   output logic                  eng_start,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [DATA_W-1:0]     res_data,
   output logic                  busy,
   output logic [31:0]           perf_busy_cyc,
   output logic [31:0]           perf_stall_cyc,
   output logic [3:0]            dbg_state
);

   localparam int RES_W = (RES_PAGES > 1) ? $clog2(RES_PAGES) : 1;
   localparam logic [PROG_IDX_W-1:0] PROG_LAST = PROG_IDX_W'(PROG_PAGES - 1);
   localparam logic [IMG_IDX_W-1:0]  IMG_LAST  = IMG_IDX_W'(IMG_PAGES - 1);
   localparam logic [RES_W-1:0]      RES_LAST  = RES_W'(RES_PAGES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PROG_REQ, S_PROG_WAIT, S_EXEC, S_WT_LOAD,
      S_IMG_ENG, S_IMG_REQ, S_IMG_WAIT, S_RES_WR
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     buf_base_q, buf_base_d;
   logic [PROG_IDX_W-1:0] prog_cnt_q, prog_cnt_d;
   logic [CH_W-1:0]       ch_q, ch_d;
   logic [ADDR_W-1:0]     wt_addr_q, wt_addr_d;
   logic [ADDR_W-1:0]     img_addr_q, img_addr_d;
   logic [ADDR_W-1:0]     rslt_addr_q, rslt_addr_d;
   logic [CNT_W-1:0]      img_cnt_q, img_cnt_d;
   logic [IMG_IDX_W-1:0]  img_pg_q, img_pg_d;
   logic [RES_W-1:0]      res_pg_q, res_pg_d;
   logic                  rd_req_q, rd_req_d;
   logic                  rd_out_q, rd_out_d;
   logic                  instr_vld_q, instr_vld_d;
   logic                  inc_pc_q, inc_pc_d;
   logic                  eng_start_q, eng_start_d;

   // Read data is consumed directly by the engines off the shared bus.
   logic unused_rd_data;
   assign unused_rd_data = ^mem_rd_data;

   // Next-state, register-file writes and stream bookkeeping.
   always_comb begin
      state_d     = state_q;
      buf_base_d  = buf_base_q;
      prog_cnt_d  = prog_cnt_q;
      ch_d        = ch_q;
      wt_addr_d   = wt_addr_q;
      img_addr_d  = img_addr_q;
      rslt_addr_d = rslt_addr_q;
      img_cnt_d   = img_cnt_q;
      img_pg_d    = img_pg_q;
      res_pg_d    = res_pg_q;
      rd_req_d    = rd_req_q;
      rd_out_d    = rd_out_q;
      instr_vld_d = 1'b0;
      inc_pc_d    = 1'b0;
      eng_start_d = 1'b0;

      // Register writes land only while idle/executing; a command accepted
      // in the same cycle decides on the old value.
      if (reg_wr_en && (state_q == S_IDLE || state_q == S_EXEC)) begin
         case (reg_sel)
            2'b00:   img_addr_d  = ADDR_W'(reg_data);
            2'b01:   img_cnt_d   = reg_data;
            2'b10:   rslt_addr_d = ADDR_W'(reg_data);
            default: ;
         endcase
      end

      case (state_q)
         S_IDLE: begin
            if (buffer_addr_valid) begin
               buf_base_d = buf_base;
               prog_cnt_d = '0;
               state_d    = S_PROG_REQ;
            end
         end
         S_PROG_REQ: if (mem_rd_ready) state_d = S_PROG_WAIT;
         S_PROG_WAIT: begin
            if (mem_rd_dvalid) begin
               if (prog_cnt_q == PROG_LAST) begin
                  instr_vld_d = 1'b1;
                  state_d     = S_EXEC;
               end else begin
                  prog_cnt_d = prog_cnt_q + PROG_IDX_W'(1);
                  state_d    = S_PROG_REQ;
               end
            end
         end
         S_EXEC: begin
            if (cmd_valid) begin
               if (!cmd_op) begin
                  ch_d      = cmd_ch;
                  wt_addr_d = ADDR_W'(cmd_addr);
                  rd_req_d  = 1'b0;
                  rd_out_d  = 1'b0;
                  state_d   = S_WT_LOAD;
               end else if (img_cnt_q == '0) begin
                  inc_pc_d = 1'b1;
               end else begin
                  state_d = S_IMG_ENG;
               end
            end
         end
         S_WT_LOAD: begin
            // Only the selected channel is served; done waits for the bus.
            if (rd_out_q) begin
               if (mem_rd_dvalid) begin
                  rd_out_d  = 1'b0;
                  wt_addr_d = wt_addr_q + ADDR_W'(1);
               end
            end else if (rd_req_q) begin
               if (mem_rd_ready) begin
                  rd_req_d = 1'b0;
                  rd_out_d = 1'b1;
               end
            end else if (wt_done[ch_q]) begin
               inc_pc_d = 1'b1;
               state_d  = S_EXEC;
            end else if (wt_req[ch_q]) begin
               rd_req_d = 1'b1;
            end
         end
         S_IMG_ENG: begin
            if (eng_ready) begin
               img_pg_d = '0;
               state_d  = S_IMG_REQ;
            end
         end
         S_IMG_REQ: if (mem_rd_ready) state_d = S_IMG_WAIT;
         S_IMG_WAIT: begin
            if (mem_rd_dvalid) begin
               img_addr_d = img_addr_q + ADDR_W'(1);
               if (img_pg_q == IMG_LAST) begin
                  eng_start_d = 1'b1;
                  img_cnt_d   = img_cnt_q - CNT_W'(1);
                  res_pg_d    = '0;
                  state_d     = S_RES_WR;
               end else begin
                  img_pg_d = img_pg_q + IMG_IDX_W'(1);
                  state_d  = S_IMG_REQ;
               end
            end
         end
         S_RES_WR: begin
            if (res_valid && mem_wr_ready) begin
               rslt_addr_d = rslt_addr_q + ADDR_W'(1);
               if (res_pg_q == RES_LAST) begin
                  if (img_cnt_q == '0) begin
                     inc_pc_d = 1'b1;
                     state_d  = S_EXEC;
                  end else begin
                     state_d = S_IMG_ENG;
                  end
               end else begin
                  res_pg_d = res_pg_q + RES_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         buf_base_q  <= '0;
         prog_cnt_q  <= '0;
         ch_q        <= '0;
         wt_addr_q   <= '0;
         img_addr_q  <= '0;
         rslt_addr_q <= '0;
         img_cnt_q   <= '0;
         img_pg_q    <= '0;
         res_pg_q    <= '0;
         rd_req_q    <= 1'b0;
         rd_out_q    <= 1'b0;
         instr_vld_q <= 1'b0;
         inc_pc_q    <= 1'b0;
         eng_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_base_q  <= buf_base_d;
         prog_cnt_q  <= prog_cnt_d;
         ch_q        <= ch_d;
         wt_addr_q   <= wt_addr_d;
         img_addr_q  <= img_addr_d;
         rslt_addr_q <= rslt_addr_d;
         img_cnt_q   <= img_cnt_d;
         img_pg_q    <= img_pg_d;
         res_pg_q    <= res_pg_d;
         rd_req_q    <= rd_req_d;
         rd_out_q    <= rd_out_d;
         instr_vld_q <= instr_vld_d;
         inc_pc_q    <= inc_pc_d;
         eng_start_q <= eng_start_d;
      end
   end

   // Memory-side outputs decoded from the current state.
   always_comb begin
      mem_addr = '0;
      case (state_q)
         S_PROG_REQ: mem_addr = buf_base_q + ADDR_W'(prog_cnt_q);
         S_WT_LOAD:  mem_addr = wt_addr_q;
         S_IMG_REQ:  mem_addr = img_addr_q;
         S_RES_WR:   mem_addr = rslt_addr_q;
         default:    mem_addr = '0;
      endcase
   end

   assign mem_rd_valid  = (state_q == S_PROG_REQ) || (state_q == S_IMG_REQ) ||
                          ((state_q == S_WT_LOAD) && rd_req_q);
   assign mem_wr_valid  = (state_q == S_RES_WR) && res_valid;
   assign res_ready     = (state_q == S_RES_WR) && mem_wr_ready;
   assign mem_wr_data   = res_data;
   assign prog_page_vld = (state_q == S_PROG_WAIT) && mem_rd_dvalid;
   assign prog_page_idx = prog_cnt_q;
   assign img_page_vld  = (state_q == S_IMG_WAIT) && mem_rd_dvalid;
   assign img_page_idx  = img_pg_q;
   assign wt_dvalid     = ((state_q == S_WT_LOAD) && rd_out_q && mem_rd_dvalid) ?
                          (NUM_WCH'(1) << ch_q) : '0;
   assign cmd_ready     = (state_q == S_EXEC);
   assign busy          = (state_q != S_IDLE) && (state_q != S_EXEC);
   assign instr_vld     = instr_vld_q;
   assign inc_pc        = inc_pc_q;
   assign eng_start     = eng_start_q;
   assign dbg_state     = state_q;

`ifdef CTRL_SEQ_PERF_EN
   logic [31:0] busy_cyc_q, busy_cyc_d, stall_cyc_q, stall_cyc_d;
   logic        stall;

   assign stall = (mem_rd_valid && !mem_rd_ready) || (mem_wr_valid && !mem_wr_ready);

   // Saturating busy / bus-stall cycle counters.
   always_comb begin
      busy_cyc_d  = busy_cyc_q;
      stall_cyc_d = stall_cyc_q;
      if (busy && (busy_cyc_q != '1)) busy_cyc_d = busy_cyc_q + 32'd1;
      if (stall && (stall_cyc_q != '1)) stall_cyc_d = stall_cyc_q + 32'd1;
   end

   // Counter registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cyc_q  <= '0;
         stall_cyc_q <= '0;
      end else begin
         busy_cyc_q  <= busy_cyc_d;
         stall_cyc_q <= stall_cyc_d;
      end
   end

   assign perf_busy_cyc  = busy_cyc_q;
   assign perf_stall_cyc = stall_cyc_q;
`else
   assign perf_busy_cyc  = '0;
   assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed test of ctrl_sequencer with a small memory
// responder and an event scoreboard (expected events queued, monitor pops).
module tb_ctrl_sequencer;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 28;

   localparam logic [7:0] K_RD = 8'd1, K_WR = 8'd2, K_PG = 8'd3, K_INSTR = 8'd4;
   localparam logic [7:0] K_INC = 8'd5, K_WTD = 8'd6, K_IMG = 8'd7, K_ENG = 8'd8;

   logic              clk, rst;
   logic              buffer_addr_valid;
   logic [ADDR_W-1:0] buf_base, mem_addr;
   logic              mem_rd_valid, mem_rd_ready, mem_rd_dvalid;
   logic [DATA_W-1:0] mem_rd_data, mem_wr_data, res_data;
   logic              mem_wr_valid, mem_wr_ready;
   logic              prog_page_vld, instr_vld, inc_pc;
   logic [1:0]        prog_page_idx, img_page_idx;
   logic              cmd_valid, cmd_ready, cmd_op;
   logic [0:0]        cmd_ch;
   logic [CNT_W-1:0]  cmd_addr, reg_data;
   logic              reg_wr_en;
   logic [1:0]        reg_sel;
   logic [1:0]        wt_req, wt_done, wt_dvalid;
   logic              eng_ready, img_page_vld, eng_start;
   logic              res_valid, res_ready, busy;
   logic [31:0]       perf_busy_cyc, perf_stall_cyc;
   logic [3:0]        dbg_state;

   logic [39:0] exp_q[$];
   int          total, bad;

   // responder state
   logic        mem_auto, rd_pend, wr_tog;
   logic [31:0] pend_addr, cyc;
   int          rd_wait, rd_delay, rd_delay_after;

   ctrl_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROG_PAGES(4), .IMG_PAGES(4),
      .RES_PAGES(3), .NUM_WCH(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .buffer_addr_valid(buffer_addr_valid), .buf_base(buf_base),
      .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
      .mem_rd_dvalid(mem_rd_dvalid), .mem_rd_data(mem_rd_data),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
      .prog_page_vld(prog_page_vld), .prog_page_idx(prog_page_idx),
      .instr_vld(instr_vld), .inc_pc(inc_pc),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
      .cmd_addr(cmd_addr), .reg_wr_en(reg_wr_en), .reg_sel(reg_sel), .reg_data(reg_data),
      .wt_req(wt_req), .wt_done(wt_done), .wt_dvalid(wt_dvalid),
      .eng_ready(eng_ready), .img_page_vld(img_page_vld), .img_page_idx(img_page_idx),
      .eng_start(eng_start), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .busy(busy), .perf_busy_cyc(perf_busy_cyc),
      .perf_stall_cyc(perf_stall_cyc), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input logic [7:0] k, input logic [31:0] v);
      exp_q.push_back({k, v});
   endtask

   task automatic check_ev(input logic [7:0] k, input logic [31:0] v);
      logic [39:0] got, want;
      got = {k, v};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event actual=%010h required=none", got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            bad++;
            $display("FAIL event actual=%010h required=%010h", got, want);
         end
      end
   endtask

   // bounded wait sampled on negedges: 0=cmd_ready, 1=wt_dvalid[1], 2=eng_start
   task automatic wait_sig(input string name, input int which, input int budget);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = cmd_ready;
            1:       hit = wt_dvalid[1];
            2:       hit = eng_start;
            default: hit = 1'b1;
         endcase
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL %s timeout actual=%0d_cycles required=event", name, n);
      end
   endtask

   task automatic chk_idle(input string p);
      chk({p, "_state"}, 64'(dbg_state), 64'd0);
      chk({p, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({p, "_rd_valid"}, 64'(mem_rd_valid), 64'd0);
      chk({p, "_wr_valid"}, 64'(mem_wr_valid), 64'd0);
      chk({p, "_prog_vld"}, 64'(prog_page_vld), 64'd0);
      chk({p, "_instr_vld"}, 64'(instr_vld), 64'd0);
      chk({p, "_inc_pc"}, 64'(inc_pc), 64'd0);
      chk({p, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
      chk({p, "_wt_dvalid"}, 64'(wt_dvalid), 64'd0);
      chk({p, "_img_vld"}, 64'(img_page_vld), 64'd0);
      chk({p, "_eng_start"}, 64'(eng_start), 64'd0);
      chk({p, "_res_ready"}, 64'(res_ready), 64'd0);
      chk({p, "_busy"}, 64'(busy), 64'd0);
      chk({p, "_perf_busy"}, 64'(perf_busy_cyc), 64'd0);
      chk({p, "_perf_stall"}, 64'(perf_stall_cyc), 64'd0);
   endtask

   // ---------------- memory responder ----------------
   initial begin
      mem_rd_ready  = 1'b0;
      mem_rd_dvalid = 1'b0;
      mem_rd_data   = '0;
      mem_wr_ready  = 1'b0;
      res_data      = '0;
      rd_pend       = 1'b0;
      wr_tog        = 1'b0;
      pend_addr     = '0;
      rd_wait       = 0;
      cyc           = '0;
      forever begin
         step();
         cyc++;
         res_data = {32'hC0DE0000, cyc};
         if (mem_auto) begin
            mem_rd_ready  = 1'b0;
            mem_rd_dvalid = 1'b0;
            mem_wr_ready  = wr_tog;
            wr_tog        = !wr_tog;
            if (rd_pend) begin
               mem_rd_dvalid = 1'b1;
               mem_rd_data   = {32'hDA7A0000, pend_addr};
               rd_pend       = 1'b0;
            end else if (mem_rd_valid) begin
               if (rd_wait < rd_delay) begin
                  rd_wait++;
               end else begin
                  mem_rd_ready = 1'b1;
                  rd_pend      = 1'b1;
                  pend_addr    = mem_addr;
                  rd_wait      = 0;
                  rd_delay     = rd_delay_after;
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prog_page_vld) check_ev(K_PG, 32'(prog_page_idx));
            if (instr_vld) check_ev(K_INSTR, 32'd0);
            if (img_page_vld) check_ev(K_IMG, 32'(img_page_idx));
            if (eng_start) check_ev(K_ENG, 32'd0);
            if (wt_dvalid != '0) check_ev(K_WTD, 32'(wt_dvalid));
            if (inc_pc) check_ev(K_INC, 32'd0);
            if (mem_rd_valid && mem_rd_ready) check_ev(K_RD, mem_addr);
            if (mem_wr_valid && mem_wr_ready) begin
               check_ev(K_WR, mem_addr);
               chk("wr_data", mem_wr_data, res_data);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      total = 0; bad = 0;
      rst = 1'b1; mem_auto = 1'b1; rd_delay = 0; rd_delay_after = 0;
      buffer_addr_valid = 1'b0; buf_base = '0;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ch = '0; cmd_addr = '0;
      reg_wr_en = 1'b0; reg_sel = '0; reg_data = '0;
      wt_req = '0; wt_done = '0; eng_ready = 1'b0; res_valid = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk_idle("reset");
      step();

      // program load: first read stalled 5 cycles
      rd_delay = 5; rd_delay_after = 0;
      for (int p = 0; p < 4; p++) begin
         expect_ev(K_RD, 32'h100 + 32'(p));
         expect_ev(K_PG, 32'(p));
      end
      expect_ev(K_INSTR, 32'd0);
      buf_base = 32'h100; buffer_addr_valid = 1'b1;
      step();
      buffer_addr_valid = 1'b0; buf_base = 32'hDEAD0000;
      wait_sig("prog_load", 0, 200);
`ifdef CTRL_SEQ_PERF_EN
      chk("perf_stall", 64'(perf_stall_cyc), 64'd5);
      chk("perf_busy_nonzero", 64'(perf_busy_cyc != 32'd0), 64'd1);
`else
      chk("perf_stall", 64'(perf_stall_cyc), 64'd0);
      chk("perf_busy", 64'(perf_busy_cyc), 64'd0);
`endif
      chk("exec_not_busy", 64'(busy), 64'd0);
      step();

      // weight load, channel 1 at 0x40, ready delayed 2 cycles per read
      rd_delay = 2; rd_delay_after = 2;
      for (int k = 0; k < 3; k++) begin
         expect_ev(K_RD, 32'h40 + 32'(k));
         expect_ev(K_WTD, 32'h2);
      end
      expect_ev(K_INC, 32'd0);
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_ch = 1'b1; cmd_addr = 28'h40;
      step();
      cmd_valid = 1'b0;
      wt_req = 2'b01; wt_done = 2'b01;
      step();
      wt_req = '0; wt_done = '0;
      step();
      for (int k = 0; k < 3; k++) begin
         wt_req = 2'b10;
         step();
         wt_req = '0;
         wait_sig("wt_dvalid", 1, 50);
         step();
      end
      wt_done = 2'b10;
      step();
      wt_done = '0;
      wait_sig("wt_exit", 0, 20);
      step();
      rd_delay = 0; rd_delay_after = 0;

      // process with img_cnt=0 while writing img_cnt=2 in the same cycle
      expect_ev(K_INC, 32'd0);
      cmd_valid = 1'b1; cmd_op = 1'b1;
      reg_wr_en = 1'b1; reg_sel = 2'b01; reg_data = 28'd2;
      step();
      cmd_valid = 1'b0; reg_wr_en = 1'b0;
      @(negedge clk);
      chk("zero_img_inc_pc", 64'(inc_pc), 64'd1);
      chk("zero_img_no_read", 64'(mem_rd_valid), 64'd0);
      chk("zero_img_state_exec", 64'(cmd_ready), 64'd1);
      step();

      // two images: img_addr 0x200, rslt_addr 0x900
      reg_wr_en = 1'b1; reg_sel = 2'b00; reg_data = 28'h200;
      step();
      reg_sel = 2'b10; reg_data = 28'h900;
      step();
      reg_wr_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         for (int p = 0; p < 4; p++) begin
            expect_ev(K_RD, 32'h200 + 32'(4 * i + p));
            expect_ev(K_IMG, 32'(p));
         end
         expect_ev(K_ENG, 32'd0);
         for (int r = 0; r < 3; r++) expect_ev(K_WR, 32'h900 + 32'(3 * i + r));
      end
      expect_ev(K_INC, 32'd0);
      res_valid = 1'b1;
      cmd_valid = 1'b1; cmd_op = 1'b1;
      step();
      cmd_valid = 1'b0;
      reg_wr_en = 1'b1; reg_sel = 2'b10; reg_data = 28'h500;
      step();
      reg_wr_en = 1'b0;
      @(negedge clk);
      chk("img_wait_busy", 64'(busy), 64'd1);
      chk("img_wait_no_read", 64'(mem_rd_valid), 64'd0);
      step();
      eng_ready = 1'b1;
      wait_sig("img_done", 0, 400);
      step();
      res_valid = 1'b0;

      // reset in the middle of result write-back, then a stray read return
      reg_wr_en = 1'b1; reg_sel = 2'b01; reg_data = 28'd1;
      step();
      reg_sel = 2'b00; reg_data = 28'h300;
      step();
      reg_wr_en = 1'b0;
      for (int p = 0; p < 4; p++) begin
         expect_ev(K_RD, 32'h300 + 32'(p));
         expect_ev(K_IMG, 32'(p));
      end
      expect_ev(K_ENG, 32'd0);
      cmd_valid = 1'b1; cmd_op = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_sig("rst_eng_start", 2, 200);
      step();
      @(negedge clk);
      chk("mid_res_wr_state", 64'(dbg_state), 64'd8);
      step();
      mem_auto = 1'b0; rst = 1'b1;
      mem_rd_ready = 1'b0; mem_rd_dvalid = 1'b0; mem_wr_ready = 1'b0;
      step();
      step();
      rst = 1'b0; mem_rd_dvalid = 1'b1;
      @(negedge clk);
      chk_idle("post_rst");
      step();
      mem_rd_dvalid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk_idle("post_rst_late");

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
